// File: rtl/life_pkg.sv
// Shared types and default geometry for the Game-of-Life datapath blocks.
package life_pkg;

  localparam int LIFE_LINE_WIDTH = 8;
  localparam int LIFE_ADDR_SIZE  = 3;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    WAIT,
    PRESENT
  } rwr_state_t;

  typedef enum logic [1:0] {
    SLOT_ABOVE,
    SLOT_CUR,
    SLOT_BELOW
  } slot_t;

endpackage

// File: rtl/read_tag_pipe.sv
// Delays a read-issued flag and its destination slot so the capture lines up
// with the returning buffer data.
module read_tag_pipe
  import life_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  vld_i,
  input  slot_t slot_i,
  output logic  vld_o,
  output slot_t slot_o
);

  logic  vld_q  [DEPTH];
  slot_t slot_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_q[i]  <= 1'b0;
        slot_q[i] <= SLOT_ABOVE;
      end
    end else begin
      vld_q[0]  <= vld_i;
      slot_q[0] <= slot_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i]  <= vld_q[i-1];
        slot_q[i] <= slot_q[i-1];
      end
    end
  end

  assign vld_o  = vld_q[DEPTH-1];
  assign slot_o = slot_q[DEPTH-1];

endmodule

// File: rtl/row_window_reader.sv
// Streams the previous generation as 3-row windows (above, cur, below) with
// vertical wrap, reading rows from the double-buffer logic port.
//   state   | meaning
//   IDLE    | no scan; waits for start_in
//   PRIME   | issues reads for rows N-1, 0, 1 and waits for all three
//   WAIT    | one refill read of the new below row in flight
//   PRESENT | window valid, waiting for the consumer to accept
module row_window_reader
  import life_pkg::*;
#(
  parameter int LINE_WIDTH   = LIFE_LINE_WIDTH,
  parameter int ADDR_SIZE    = LIFE_ADDR_SIZE,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  output logic [ADDR_SIZE-1:0]  addr_r_out,
  input  logic [LINE_WIDTH-1:0] data_in,
  output logic [LINE_WIDTH-1:0] above_out,
  output logic [LINE_WIDTH-1:0] cur_out,
  output logic [LINE_WIDTH-1:0] below_out,
  output logic [ADDR_SIZE-1:0]  row_idx_out,
  output logic                  row_valid_out,
  input  logic                  row_ready_in,
  output logic                  busy_out,
  output logic                  done_out
);

  if (ADDR_SIZE < 2) begin : g_bad_addr_size
    $error("row_window_reader: ADDR_SIZE must be at least 2");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_latency
    $error("row_window_reader: READ_LATENCY must be 1 or 2");
  end

  rwr_state_t            state_q, state_d;
  logic [ADDR_SIZE-1:0]  addr_q, addr_d;
  logic                  iss_vld_q, iss_vld_d;
  slot_t                 iss_slot_q, iss_slot_d;
  logic [1:0]            prime_cnt_q, prime_cnt_d;
  logic [LINE_WIDTH-1:0] above_q, above_d;
  logic [LINE_WIDTH-1:0] cur_q, cur_d;
  logic [LINE_WIDTH-1:0] below_q, below_d;
  logic [ADDR_SIZE-1:0]  idx_q, idx_d;
  logic                  done_q, done_d;

  logic                  cap_vld;
  slot_t                 cap_slot;

  // The issue flag is registered alongside addr_r_out, so the pipe only has to
  // add the buffer's read latency on top of it.
  read_tag_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_tag_pipe (
    .clk_i  (clk_in),
    .rst_i  (rst_in),
    .vld_i  (iss_vld_q),
    .slot_i (iss_slot_q),
    .vld_o  (cap_vld),
    .slot_o (cap_slot)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    iss_vld_d   = 1'b0;
    iss_slot_d  = iss_slot_q;
    prime_cnt_d = prime_cnt_q;
    above_d     = above_q;
    cur_d       = cur_q;
    below_d     = below_q;
    idx_d       = idx_q;
    done_d      = 1'b0;

    if (cap_vld) begin
      case (cap_slot)
        SLOT_ABOVE: above_d = data_in;
        SLOT_CUR:   cur_d   = data_in;
        SLOT_BELOW: below_d = data_in;
        default:    below_d = data_in;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d     = PRIME;
          addr_d      = '1;
          iss_vld_d   = 1'b1;
          iss_slot_d  = SLOT_ABOVE;
          prime_cnt_d = 2'd0;
          idx_d       = '0;
        end
      end
      PRIME: begin
        if (prime_cnt_q == 2'd0) begin
          addr_d      = '0;
          iss_vld_d   = 1'b1;
          iss_slot_d  = SLOT_CUR;
          prime_cnt_d = 2'd1;
        end else if (prime_cnt_q == 2'd1) begin
          addr_d      = ADDR_SIZE'(1);
          iss_vld_d   = 1'b1;
          iss_slot_d  = SLOT_BELOW;
          prime_cnt_d = 2'd2;
        end
        if (cap_vld && cap_slot == SLOT_BELOW) begin
          state_d = PRESENT;
        end
      end
      WAIT: begin
        if (cap_vld) begin
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (row_ready_in) begin
          if (idx_q == {ADDR_SIZE{1'b1}}) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            // Slide the window down; the new below row wraps past N-1 to 0.
            above_d    = cur_q;
            cur_d      = below_q;
            idx_d      = idx_q + ADDR_SIZE'(1);
            addr_d     = idx_q + ADDR_SIZE'(2);
            iss_vld_d  = 1'b1;
            iss_slot_d = SLOT_BELOW;
            state_d    = WAIT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      iss_vld_q   <= 1'b0;
      iss_slot_q  <= SLOT_ABOVE;
      prime_cnt_q <= 2'd0;
      above_q     <= '0;
      cur_q       <= '0;
      below_q     <= '0;
      idx_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      iss_vld_q   <= iss_vld_d;
      iss_slot_q  <= iss_slot_d;
      prime_cnt_q <= prime_cnt_d;
      above_q     <= above_d;
      cur_q       <= cur_d;
      below_q     <= below_d;
      idx_q       <= idx_d;
      done_q      <= done_d;
    end
  end

  assign addr_r_out    = addr_q;
  assign above_out     = above_q;
  assign cur_out       = cur_q;
  assign below_out     = below_q;
  assign row_idx_out   = idx_q;
  assign row_valid_out = (state_q == PRESENT);
  assign busy_out      = (state_q != IDLE);
  assign done_out      = done_q;

endmodule
